// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - Forwarding select encodings for the EX operand muxes.
//   - Control-bit group carried by every stage record (EX/MEM/WB).
//   - Helper that decides whether a stage record may feed a forward.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memread;
    } stage_ctl_t;

    // A record can source a forward if it is a real register-writing
    // instruction. Loads are only allowed where the data already exists (WB).
    function automatic logic can_fwd(input stage_ctl_t ctl, input logic allow_load);
        return ctl.valid & ctl.regwrite & (allow_load | ~ctl.memread);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding comparator for the EX stage operands.
// Purely combinational: compares the EX source registers against the
// destination registers held in the MEM and WB records.
// Ports:
//   ex_rs1, ex_rs2           EX source register addresses
//   ex_rs1_used, ex_rs2_used EX instruction actually reads the operand
//   mem_ctl, mem_rd          MEM record control bits and destination
//   wb_ctl, wb_rd            WB record control bits and destination
//   fwd_a_sel, fwd_b_sel     operand source: FWD_REG / FWD_MEM / FWD_WB
module hazard_ctrl_fwd_unit
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] ex_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rs2,
    input  logic                      ex_rs1_used,
    input  logic                      ex_rs2_used,
    input  stage_ctl_t                mem_ctl,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  stage_ctl_t                wb_ctl,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic [1:0]                fwd_a_sel,
    output logic [1:0]                fwd_b_sel
);

    // MEM wins over WB because it holds the younger write to the register.
    function automatic logic [1:0] pick_src(input logic [REG_ADDR_WIDTH-1:0] rs,
                                            input logic                      used);
        logic [1:0] sel;
        sel = FWD_REG;
        if (used && (rs != '0)) begin
            if (can_fwd(mem_ctl, 1'b0) && (mem_rd == rs)) begin
                sel = FWD_MEM;
            end else if (can_fwd(wb_ctl, 1'b1) && (wb_rd == rs)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a_sel = pick_src(ex_rs1, ex_rs1_used);
        fwd_b_sel = pick_src(ex_rs2, ex_rs2_used);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core.
// Tracks the instructions in EX, MEM and WB and derives stall, bubble,
// flush and forwarding controls, plus saturating stall/flush counters.
// Ports:
//   clk, rst_n              clock; synchronous active-low reset
//   id_*                    decoded fields of the instruction in ID
//   ex_branch_taken         EX resolved a taken branch/jump
//   mem_busy                data memory not ready; freeze pipeline
//   pc_stall, if_id_stall   hold PC / IF-ID register
//   if_id_flush             clear IF-ID to NOP
//   id_ex_bubble            load NOP into ID-EX
//   ex_mem_stall            hold ID-EX and EX-MEM; MEM-WB takes bubble
//   fwd_a_sel, fwd_b_sel    EX operand source selects
//   stall_cnt, flush_cnt    saturating performance counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic                      id_regwrite,
    input  logic                      id_memread,
    input  logic                      ex_branch_taken,
    input  logic                      mem_busy,
    output logic                      pc_stall,
    output logic                      if_id_stall,
    output logic                      if_id_flush,
    output logic                      id_ex_bubble,
    output logic                      ex_mem_stall,
    output logic [1:0]                fwd_a_sel,
    output logic [1:0]                fwd_b_sel,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt
);

    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    // Stage records
    stage_ctl_t                ex_ctl_q, mem_ctl_q, wb_ctl_q;
    logic [REG_ADDR_WIDTH-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q, mem_rd_q, wb_rd_q;
    logic                      ex_rs1_used_q, ex_rs2_used_q;

    logic [CNT_WIDTH-1:0]      stall_cnt_q, flush_cnt_q;
    logic                      load_use;

    always_comb begin
        load_use = ex_ctl_q.valid & ex_ctl_q.memread & (ex_rd_q != '0) & id_valid &
                   ((id_rs1_used & (id_rs1_addr == ex_rd_q)) |
                    (id_rs2_used & (id_rs2_addr == ex_rd_q)));

        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_stall = 1'b0;
        // A busy memory freezes EX, so a pending branch simply waits for it.
        if (mem_busy) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            ex_mem_stall = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_ctl_q      <= '0;
            mem_ctl_q     <= '0;
            wb_ctl_q      <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_rs1_used_q <= 1'b0;
            ex_rs2_used_q <= 1'b0;
            mem_rd_q      <= '0;
            wb_rd_q       <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            if (mem_busy) begin
                // EX and MEM hold; the slot leaving MEM is a bubble.
                wb_ctl_q.valid <= 1'b0;
            end else begin
                wb_ctl_q      <= mem_ctl_q;
                wb_rd_q       <= mem_rd_q;
                mem_ctl_q     <= ex_ctl_q;
                mem_rd_q      <= ex_rd_q;
                ex_ctl_q      <= '{valid:    id_valid & ~(id_ex_bubble | if_id_flush),
                                   regwrite: id_regwrite,
                                   memread:  id_memread};
                ex_rs1_q      <= id_rs1_addr;
                ex_rs2_q      <= id_rs2_addr;
                ex_rd_q       <= id_rd_addr;
                ex_rs1_used_q <= id_rs1_used;
                ex_rs2_used_q <= id_rs2_used;
            end
            if (pc_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CntOne;
            end
            if (if_id_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CntOne;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    hazard_ctrl_fwd_unit #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_unit (
        .ex_rs1      (ex_rs1_q),
        .ex_rs2      (ex_rs2_q),
        .ex_rs1_used (ex_rs1_used_q),
        .ex_rs2_used (ex_rs2_used_q),
        .mem_ctl     (mem_ctl_q),
        .mem_rd      (mem_rd_q),
        .wb_ctl      (wb_ctl_q),
        .wb_rd       (wb_rd_q),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: an instruction-level pipeline model
// checked against the DUT every cycle, plus directed literal expectations.
module tb_hazard_ctrl;

    localparam int RW   = 5;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [RW-1:0] id_rs1_addr = '0;
    logic [RW-1:0] id_rs2_addr = '0;
    logic          id_rs1_used = 1'b0;
    logic          id_rs2_used = 1'b0;
    logic [RW-1:0] id_rd_addr = '0;
    logic          id_regwrite = 1'b0;
    logic          id_memread = 1'b0;
    logic          ex_branch_taken = 1'b0;
    logic          mem_busy = 1'b0;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_mem_stall;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    hazard_ctrl #(
        .REG_ADDR_WIDTH (RW),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .id_rd_addr      (id_rd_addr),
        .id_regwrite     (id_regwrite),
        .id_memread      (id_memread),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .ex_mem_stall    (ex_mem_stall),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit v;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
        int rd;
        bit rw;
        bit mr;
    } rec_t;

    rec_t st[3];        // 0 = EX, 1 = MEM, 2 = WB
    int   m_stall = 0;
    int   m_flush = 0;
    bit   model_ok = 1'b0;

    function automatic bit m_load_use();
        return st[0].v && st[0].mr && st[0].rd != 0 && id_valid &&
               ((id_rs1_used && int'(id_rs1_addr) == st[0].rd) ||
                (id_rs2_used && int'(id_rs2_addr) == st[0].rd));
    endfunction

    function automatic int m_fwd(input int r, input bit used);
        if (!used || r == 0) return 0;
        if (st[1].v && st[1].rw && !st[1].mr && st[1].rd == r) return 1;
        if (st[2].v && st[2].rw && st[2].rd == r) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin : model_step
        bit lu;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) st[i] = '{default: 0};
            m_stall  = 0;
            m_flush  = 0;
            model_ok = 1'b1;
        end else begin
            lu = m_load_use();
            if (mem_busy) begin
                st[2].v = 1'b0;
                if (m_stall < CMAX) m_stall++;
            end else begin
                if (ex_branch_taken) begin
                    if (m_flush < CMAX) m_flush++;
                end else if (lu) begin
                    if (m_stall < CMAX) m_stall++;
                end
                st[2] = st[1];
                st[1] = st[0];
                st[0].v   = id_valid && !ex_branch_taken && !lu;
                st[0].rs1 = int'(id_rs1_addr);
                st[0].rs2 = int'(id_rs2_addr);
                st[0].u1  = id_rs1_used;
                st[0].u2  = id_rs2_used;
                st[0].rd  = int'(id_rd_addr);
                st[0].rw  = id_regwrite;
                st[0].mr  = id_memread;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit busy, br, lus;
        if (model_ok) begin
            busy = mem_busy;
            br   = ex_branch_taken && !busy;
            lus  = m_load_use() && !busy && !ex_branch_taken;
            check("m.pc_stall", 32'(pc_stall), 32'(busy || lus));
            check("m.if_id_stall", 32'(if_id_stall), 32'(busy || lus));
            check("m.if_id_flush", 32'(if_id_flush), 32'(br));
            check("m.id_ex_bubble", 32'(id_ex_bubble), 32'(br || lus));
            check("m.ex_mem_stall", 32'(ex_mem_stall), 32'(busy));
            check("m.fwd_a_sel", 32'(fwd_a_sel), 32'(m_fwd(st[0].rs1, st[0].u1)));
            check("m.fwd_b_sel", 32'(fwd_b_sel), 32'(m_fwd(st[0].rs2, st[0].u2)));
            check("m.stall_cnt", 32'(stall_cnt), 32'(m_stall));
            check("m.flush_cnt", 32'(flush_cnt), 32'(m_flush));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_mid();
        @(negedge clk);
        #1;
    endtask

    task automatic set_id(input bit v, input int rs1, input int rs2, input bit u1,
                          input bit u2, input int rd, input bit rw, input bit mr);
        id_valid    = v;
        id_rs1_addr = rs1[RW-1:0];
        id_rs2_addr = rs2[RW-1:0];
        id_rs1_used = u1;
        id_rs2_used = u2;
        id_rd_addr  = rd[RW-1:0];
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic idle(input int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) step();
    endtask

    initial begin
        step();
        step();
        rst_n = 1'b1;
        at_mid();
        check("reset.pc_stall", 32'(pc_stall), 0);
        check("reset.fwd_a", 32'(fwd_a_sel), 0);
        check("reset.stall_cnt", 32'(stall_cnt), 0);
        check("reset.flush_cnt", 32'(flush_cnt), 0);

        // lw x5,0(x2) ; add x6,x5,x1
        step();
        set_id(1, 2, 0, 1, 0, 5, 1, 1);
        step();
        set_id(1, 5, 1, 1, 1, 6, 1, 0);
        at_mid();
        check("lu.pc_stall", 32'(pc_stall), 1);
        check("lu.if_id_stall", 32'(if_id_stall), 1);
        check("lu.bubble", 32'(id_ex_bubble), 1);
        step();
        at_mid();
        check("lu.released", 32'(pc_stall), 0);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        at_mid();
        check("lu.fwd_a_wb", 32'(fwd_a_sel), 2);
        check("lu.fwd_b", 32'(fwd_b_sel), 0);
        check("lu.stall_cnt", 32'(stall_cnt), 1);
        idle(3);

        // add x5,x1,x2 ; sub x7,x5,x5
        set_id(1, 1, 2, 1, 1, 5, 1, 0);
        step();
        set_id(1, 5, 5, 1, 1, 7, 1, 0);
        at_mid();
        check("alu.no_stall", 32'(pc_stall), 0);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        at_mid();
        check("alu.fwd_a_mem", 32'(fwd_a_sel), 1);
        check("alu.fwd_b_mem", 32'(fwd_b_sel), 1);
        idle(3);

        // add x5 ; addi x9,x3 ; sub x7,x5,x5
        set_id(1, 1, 2, 1, 1, 5, 1, 0);
        step();
        set_id(1, 3, 0, 1, 0, 9, 1, 0);
        step();
        set_id(1, 5, 5, 1, 1, 7, 1, 0);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        at_mid();
        check("alu2.fwd_a_wb", 32'(fwd_a_sel), 2);
        check("alu2.fwd_b_wb", 32'(fwd_b_sel), 2);
        idle(3);

        // lw x0 ; add x6,x0,x0
        set_id(1, 2, 0, 1, 0, 0, 1, 1);
        step();
        set_id(1, 0, 0, 1, 1, 6, 1, 0);
        at_mid();
        check("x0.no_stall", 32'(pc_stall), 0);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        at_mid();
        check("x0.fwd_a", 32'(fwd_a_sel), 0);
        check("x0.fwd_b", 32'(fwd_b_sel), 0);
        idle(3);

        // Taken branch coinciding with load-use
        set_id(1, 2, 0, 1, 0, 5, 1, 1);
        step();
        set_id(1, 5, 1, 1, 1, 6, 1, 0);
        ex_branch_taken = 1'b1;
        at_mid();
        check("br.flush", 32'(if_id_flush), 1);
        check("br.bubble", 32'(id_ex_bubble), 1);
        check("br.pc_stall", 32'(pc_stall), 0);
        step();
        ex_branch_taken = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        at_mid();
        check("br.flush_cnt", 32'(flush_cnt), 1);
        check("br.stall_cnt", 32'(stall_cnt), 1);
        idle(3);

        // mem_busy for 3 cycles while a branch waits in EX
        mem_busy        = 1'b1;
        ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            at_mid();
            check("busy.pc_stall", 32'(pc_stall), 1);
            check("busy.ex_mem_stall", 32'(ex_mem_stall), 1);
            check("busy.no_flush", 32'(if_id_flush), 0);
            step();
        end
        mem_busy = 1'b0;
        at_mid();
        check("busy.flush_now", 32'(if_id_flush), 1);
        check("busy.stall_cnt", 32'(stall_cnt), 4);
        check("busy.flush_cnt_before", 32'(flush_cnt), 1);
        step();
        ex_branch_taken = 1'b0;
        at_mid();
        check("busy.flush_cnt_after", 32'(flush_cnt), 2);
        idle(2);

        // Reset in the middle of a load-use stall
        set_id(1, 2, 0, 1, 0, 5, 1, 1);
        step();
        set_id(1, 5, 1, 1, 1, 6, 1, 0);
        at_mid();
        check("rst.stall_active", 32'(pc_stall), 1);
        rst_n = 1'b0;
        step();
        at_mid();
        check("rst.pc_stall", 32'(pc_stall), 0);
        check("rst.bubble", 32'(id_ex_bubble), 0);
        check("rst.stall_cnt", 32'(stall_cnt), 0);
        check("rst.flush_cnt", 32'(flush_cnt), 0);
        rst_n = 1'b1;
        idle(2);

        // Stall counter saturation
        mem_busy = 1'b1;
        repeat (20) step();
        at_mid();
        check("sat.stall_cnt", 32'(stall_cnt), CMAX);
        step();
        at_mid();
        check("sat.stall_cnt_hold", 32'(stall_cnt), CMAX);
        mem_busy = 1'b0;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
